// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields and ALU function codes.
// Imported by the decode stage and by the downstream ALU.
package decode_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_OR  = 4'b0100
    } alu_fun_e;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I decoder for the R-type and I-type arithmetic/logic subset.
// Unsupported encodings produce an all-zero entry with illegal_o set.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN   = decode_pkg::XLEN,
    parameter int REG_AW = decode_pkg::REG_AW
) (
    input  logic [XLEN-1:0]   instr_i,
    output logic              alu_sel_o,
    output logic [3:0]        alu_fun_o,
    output logic [XLEN-1:0]   imm_ext_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_we_o,
    output logic              illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    logic       is_imm;
    alu_fun_e   fun;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        // NOTE: every output gets a default first so no path through the cases infers a latch.
        legal      = 1'b0;
        is_imm     = 1'b0;
        fun        = ALU_ADD;
        alu_sel_o  = 1'b0;
        alu_fun_o  = 4'b0000;
        imm_ext_o  = '0;
        rs1_addr_o = '0;
        rs2_addr_o = '0;
        rd_addr_o  = '0;
        reg_we_o   = 1'b0;

        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        legal = (funct7 == F7_BASE) || (funct7 == F7_SUB);
                        fun   = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                    end
                    F3_AND: begin legal = (funct7 == F7_BASE); fun = ALU_AND; end
                    F3_XOR: begin legal = (funct7 == F7_BASE); fun = ALU_XOR; end
                    F3_OR:  begin legal = (funct7 == F7_BASE); fun = ALU_OR;  end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                is_imm = 1'b1;
                case (funct3)
                    F3_ADD_SUB: begin legal = 1'b1; fun = ALU_ADD; end
                    F3_AND:     begin legal = 1'b1; fun = ALU_AND; end
                    F3_XOR:     begin legal = 1'b1; fun = ALU_XOR; end
                    F3_OR:      begin legal = 1'b1; fun = ALU_OR;  end
                    default:    legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        illegal_o = !legal;

        // Illegal entries keep the all-zero defaults so the ALU never sees stray fields.
        if (legal) begin
            alu_sel_o  = is_imm;
            alu_fun_o  = fun;
            rs1_addr_o = instr_i[15 +: REG_AW];
            rs2_addr_o = is_imm ? '0 : instr_i[20 +: REG_AW];
            rd_addr_o  = instr_i[7 +: REG_AW];
            imm_ext_o  = is_imm ? {{(XLEN-12){instr_i[31]}}, instr_i[31:20]} : '0;
            reg_we_o   = (instr_i[7 +: REG_AW] != '0);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a one-entry valid/ready output register.
// Define DECODE_ILLEGAL_CNT_EN to add a saturating 16-bit illegal_cnt_o counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = decode_pkg::XLEN,
    parameter int REG_AW = decode_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              instr_valid_i,
    input  logic [XLEN-1:0]   instr_i,
    output logic              instr_ready_o,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic              alu_sel_o,
    output logic [3:0]        alu_fun_o,
    output logic [XLEN-1:0]   imm_ext_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_we_o,
    output logic              illegal_o
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]       illegal_cnt_o
`endif
);

    logic              c_alu_sel, c_reg_we, c_illegal;
    logic [3:0]        c_alu_fun;
    logic [XLEN-1:0]   c_imm_ext;
    logic [REG_AW-1:0] c_rs1, c_rs2, c_rd;

    decode_comb #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode_comb (
        .instr_i   (instr_i),
        .alu_sel_o (c_alu_sel),
        .alu_fun_o (c_alu_fun),
        .imm_ext_o (c_imm_ext),
        .rs1_addr_o(c_rs1),
        .rs2_addr_o(c_rs2),
        .rd_addr_o (c_rd),
        .reg_we_o  (c_reg_we),
        .illegal_o (c_illegal)
    );

    logic              valid_q,   valid_d;
    logic              alu_sel_q, alu_sel_d;
    logic [3:0]        alu_fun_q, alu_fun_d;
    logic [XLEN-1:0]   imm_ext_q, imm_ext_d;
    logic [REG_AW-1:0] rs1_q,     rs1_d;
    logic [REG_AW-1:0] rs2_q,     rs2_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic              reg_we_q,  reg_we_d;
    logic              illegal_q, illegal_d;
    logic              in_xfer;
    logic              out_xfer;

    assign instr_ready_o = !valid_q || dec_ready_i;
    assign in_xfer       = instr_valid_i && instr_ready_o;
    assign out_xfer      = valid_q && dec_ready_i;

    always_comb begin
        valid_d   = valid_q;
        alu_sel_d = alu_sel_q;
        alu_fun_d = alu_fun_q;
        imm_ext_d = imm_ext_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        reg_we_d  = reg_we_q;
        illegal_d = illegal_q;

        // A flushed cycle still handshakes upstream, but the accepted word is discarded.
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            valid_d   = 1'b1;
            alu_sel_d = c_alu_sel;
            alu_fun_d = c_alu_fun;
            imm_ext_d = c_imm_ext;
            rs1_d     = c_rs1;
            rs2_d     = c_rs2;
            rd_d      = c_rd;
            reg_we_d  = c_reg_we;
            illegal_d = c_illegal;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) begin
            valid_q   <= 1'b0;
            alu_sel_q <= 1'b0;
            alu_fun_q <= 4'b0000;
            imm_ext_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            reg_we_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            alu_sel_q <= alu_sel_d;
            alu_fun_q <= alu_fun_d;
            imm_ext_q <= imm_ext_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            reg_we_q  <= reg_we_d;
            illegal_q <= illegal_d;
        end
    end

    assign dec_valid_o = valid_q;
    assign alu_sel_o   = alu_sel_q;
    assign alu_fun_o   = alu_fun_q;
    assign imm_ext_o   = imm_ext_q;
    assign rs1_addr_o  = rs1_q;
    assign rs2_addr_o  = rs2_q;
    assign rd_addr_o   = rd_q;
    assign reg_we_o    = reg_we_q;
    assign illegal_o   = illegal_q;

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    // Counts delivered illegal entries; flush does not clear it.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (out_xfer && illegal_q && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_cnt_q <= 16'd0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes hand-computed entries,
// a negedge monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_decode_stage;

    typedef struct packed {
        logic        sel;
        logic [3:0]  fun;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_ready_o;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b1;
    logic        alu_sel_o;
    logic [3:0]  alu_fun_o;
    logic [31:0] imm_ext_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        reg_we_o;
    logic        illegal_o;
`ifdef DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_o;
`endif

    decode_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .instr_valid_i(instr_valid_i),
        .instr_i      (instr_i),
        .instr_ready_o(instr_ready_o),
        .dec_valid_o  (dec_valid_o),
        .dec_ready_i  (dec_ready_i),
        .alu_sel_o    (alu_sel_o),
        .alu_fun_o    (alu_fun_o),
        .imm_ext_o    (imm_ext_o),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .rd_addr_o    (rd_addr_o),
        .reg_we_o     (reg_we_o),
        .illegal_o    (illegal_o)
`ifdef DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt_o(illegal_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ill_xfers = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic sel, input logic [3:0] fun, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic we, input logic ill);
        exp_t e;
        e.sel = sel; e.fun = fun; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.we  = we;  e.ill = ill;
        return e;
    endfunction

    function automatic exp_t observed();
        return mk(alu_sel_o, alu_fun_o, imm_ext_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
                  reg_we_o, illegal_o);
    endfunction

    // Monitor: an output transfer completes at the coming edge when valid and ready are both high.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && dec_valid_o === 1'b1 && dec_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got entry 0x%0h, expected none", observed());
            end else begin
                e = sb_q.pop_front();
                check("decode_entry", observed(), e);
                if (e.ill) exp_ill_xfers++;
            end
        end
    end

    task automatic send(input logic [31:0] w, input exp_t e, input logic fl, input string name);
        int waited;
        waited = 0;
        instr_valid_i = 1'b1;
        instr_i       = w;
        flush_i       = fl;
        @(negedge clk_i);
        while (instr_ready_o !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk_i);
        end
        if (instr_ready_o !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_accept_timeout: got ready=%b, expected 1 within 20 cycles", name, instr_ready_o);
            @(posedge clk_i); #1;
            instr_valid_i = 1'b0;
            flush_i       = 1'b0;
        end else begin
            if (!fl) sb_q.push_back(e);
            @(posedge clk_i); #1;
            instr_valid_i = 1'b0;
            flush_i       = 1'b0;
            check({name, "_valid_next"}, {63'd0, dec_valid_o}, {63'd0, !fl});
        end
    endtask

    logic [31:0] vec_w[13];
    exp_t        vec_e[13];

    initial begin
        vec_w[0]  = 32'h002081B3; vec_e[0]  = mk(0, 4'h0, 32'h0,        5'd1,  5'd2,  5'd3,  1, 0);
        vec_w[1]  = 32'h407302B3; vec_e[1]  = mk(0, 4'h1, 32'h0,        5'd6,  5'd7,  5'd5,  1, 0);
        vec_w[2]  = 32'hFFF00093; vec_e[2]  = mk(1, 4'h0, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  1, 0);
        vec_w[3]  = 32'h00000013; vec_e[3]  = mk(1, 4'h0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 0);
        vec_w[4]  = 32'h00000000; vec_e[4]  = mk(0, 4'h0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1);
        vec_w[5]  = 32'h0062F233; vec_e[5]  = mk(0, 4'h2, 32'h0,        5'd5,  5'd6,  5'd4,  1, 0);
        vec_w[6]  = 32'h009443B3; vec_e[6]  = mk(0, 4'h3, 32'h0,        5'd8,  5'd9,  5'd7,  1, 0);
        vec_w[7]  = 32'h00C5E533; vec_e[7]  = mk(0, 4'h4, 32'h0,        5'd11, 5'd12, 5'd10, 1, 0);
        vec_w[8]  = 32'h7FF1F113; vec_e[8]  = mk(1, 4'h2, 32'h000007FF, 5'd3,  5'd0,  5'd2,  1, 0);
        vec_w[9]  = 32'h80024213; vec_e[9]  = mk(1, 4'h3, 32'hFFFFF800, 5'd4,  5'd0,  5'd4,  1, 0);
        vec_w[10] = 32'h4062F233; vec_e[10] = mk(0, 4'h0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1);
        vec_w[11] = 32'h00109093; vec_e[11] = mk(0, 4'h0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1);
        vec_w[12] = 32'h0010EF93; vec_e[12] = mk(1, 4'h4, 32'h00000001, 5'd1,  5'd0,  5'd31, 1, 0);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", {63'd0, dec_valid_o}, 64'd0);
        check("rst_ready", {63'd0, instr_ready_o}, 64'd1);
        check("rst_fields", observed(), 64'd0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("rst_ill_cnt", {48'd0, illegal_cnt_o}, 64'd0);
`endif
        rst_i = 1'b0;

        // Back-to-back decode of every supported and several illegal encodings
        for (int i = 0; i < 13; i++) send(vec_w[i], vec_e[i], 1'b0, "vec");
        repeat (3) @(posedge clk_i);
        #1;
        check("drain_valid", {63'd0, dec_valid_o}, 64'd0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("ill_cnt_after_vec", {48'd0, illegal_cnt_o}, 64'(exp_ill_xfers));
`endif

        // Backpressure: first entry stalls, second waits upstream
        dec_ready_i = 1'b0;
        send(vec_w[1], vec_e[1], 1'b0, "stall_a");
        instr_valid_i = 1'b1;
        instr_i       = vec_w[8];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("stall_ready", {63'd0, instr_ready_o}, 64'd0);
            check("stall_valid", {63'd0, dec_valid_o}, 64'd1);
            check("stall_hold", observed(), vec_e[1]);
        end
        @(posedge clk_i); #1;
        dec_ready_i = 1'b1;
        send(vec_w[8], vec_e[8], 1'b0, "stall_b");

        // Flush drops the word accepted in the same cycle
        send(vec_w[0], vec_e[0], 1'b1, "flush");

        // Reset while an entry is stalled
        dec_ready_i = 1'b0;
        send(vec_w[4], vec_e[4], 1'b0, "pre_rst");
        rst_i         = 1'b1;
        instr_valid_i = 1'b1;
        instr_i       = vec_w[2];
        @(posedge clk_i); #1;
        check("rst2_valid", {63'd0, dec_valid_o}, 64'd0);
        check("rst2_fields", observed(), 64'd0);
        check("rst2_ready", {63'd0, instr_ready_o}, 64'd1);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("rst2_ill_cnt", {48'd0, illegal_cnt_o}, 64'd0);
`endif
        sb_q.delete();
        exp_ill_xfers = 0;
        rst_i         = 1'b0;
        instr_valid_i = 1'b0;
        dec_ready_i   = 1'b1;

        send(vec_w[6], vec_e[6], 1'b0, "post_rst");
        repeat (3) @(posedge clk_i);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode stage that sits directly upstream of the ALU.
- Accepts a 32-bit RV32I instruction word over a valid/ready handshake.
- Decodes the R-type and I-type arithmetic/logic subset, extracts register addresses and the sign-extended immediate.
- Presents alu_sel / alu_fun / imm_ext to the ALU and rs/rd addresses to the register file, held in a one-entry output register with backpressure.

Parameters:
- XLEN, 32, datapath width of instruction and immediate.
- REG_AW, 5, register address width.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  synchronous discard of the held entry.
- instr_valid_i  input  1  instruction word valid.
- instr_i  input  XLEN  instruction word.
- instr_ready_o  output  1  stage can accept this cycle.
- dec_valid_o  output  1  decoded entry valid.
- dec_ready_i  input  1  consumer accepts the entry.
- alu_sel_o  output  1  0 selects rs2, 1 selects immediate.
- alu_fun_o  output  4  ALU operation code.
- imm_ext_o  output  XLEN  sign-extended I-type immediate.
- rs1_addr_o  output  REG_AW  source register 1.
- rs2_addr_o  output  REG_AW  source register 2.
- rd_addr_o  output  REG_AW  destination register.
- reg_we_o  output  1  register-file write enable for this entry.
- illegal_o  output  1  entry is an unsupported encoding.

Behaviour:
- Reset (rst_i=1 at edge): every output register is 0, including dec_valid_o, alu_fun_o, imm_ext_o, addresses, reg_we_o and illegal_o. Reset dominates flush and input.
- Ready rule: instr_ready_o = !dec_valid_o || dec_ready_i. This is combinational with no dependence on instr_valid_i.
- Load: an input transfer (instr_valid_i && instr_ready_o) loads the decoded fields; dec_valid_o=1 on the next cycle. Latency is exactly 1 cycle.
- Drain: an output transfer with no input transfer sets dec_valid_o=0 next cycle.
- Stall: with dec_valid_o && !dec_ready_i, all outputs are held stable.
- Back-to-back transfers sustain 1 instruction per cycle.
- flush_i=1:
  - dec_valid_o is 0 on the next cycle.
  - Any input accepted in the same cycle is dropped. instr_ready_o stays per formula, so the upstream sees the drop as a consumed word.
- R-type decode (opcode 0110011), alu_sel=0:
  - funct3 000 / funct7 0000000 → 0000 (ADD).
  - funct3 000 / funct7 0100000 → 0001 (SUB).
  - funct3 111 / funct7 0 → 0010 (AND).
  - funct3 100 / funct7 0 → 0011 (XOR).
  - funct3 110 / funct7 0 → 0100 (OR).
- I-type decode (opcode 0010011), alu_sel=1:
  - funct3 000 → 0000 (ADDI).
  - funct3 111 → 0010 (ANDI).
  - funct3 100 → 0011 (XORI).
  - funct3 110 → 0100 (ORI).
  - imm_ext = {20{instr[31]}, instr[31:20]}.
  - rs2_addr_o = 0.
- imm_ext_o is 0 for R-type.
- Field positions: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- Illegal encodings (any other opcode, funct3 or funct7 combination):
  - illegal_o=1, reg_we_o=0.
  - alu_fun_o=0000, alu_sel_o=0, imm_ext_o=0.
  - Addresses = 0.
  - dec_valid_o=1 as normal; the entry is still delivered.
- reg_we_o = legal && rd != 0. Writes to x0 are suppressed.
- No X ever propagates from outputs after reset.

Optional Feature:
- Macro: DECODE_ILLEGAL_CNT_EN.
- Defined:
  - Adds output illegal_cnt_o (16 bits), reset to 0.
  - Increments by 1 on each output transfer where illegal_o=1.
  - Saturates at 0xFFFF.
  - Not cleared by flush_i.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011.
  - funct3/funct7 constants.
  - ALU function codes ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_XOR=4'b0011, ALU_OR=4'b0100.
  - The ALU consumes the same package.
- One natural combinational sub-module, decode_comb: maps instr to {alu_sel, alu_fun, imm_ext, addrs, reg_we, illegal}.
- decode_stage wraps decode_comb with the handshake register and the optional counter.

Test Plan:
1. After reset, check that all outputs are 0 and instr_ready_o=1. Then drive 0x002081B3 (ADD x3,x1,x2) with dec_ready_i=1. Next cycle: dec_valid_o=1, alu_fun=0000, alu_sel=0, rs1=1, rs2=2, rd=3, reg_we=1, illegal=0.
2. Drive 0x407302B3 (SUB x5,x6,x7) → alu_fun=0001, rs1=6, rs2=7, rd=5.
3. Drive 0xFFF00093 (ADDI x1,x0,-1) → alu_sel=1, imm_ext=0xFFFFFFFF, rd=1, reg_we=1. Then drive 0x00000013 (ADDI x0,x0,0) → reg_we=0, illegal=0.
4. Drive 0x00000000 → illegal=1, reg_we=0, alu_fun=0000. With DECODE_ILLEGAL_CNT_EN defined, illegal_cnt_o=1 after the output transfer.
5. Backpressure: hold dec_ready_i=0 for 3 cycles with a second instruction pending. Required: instr_ready_o=0 and outputs held stable throughout. Release dec_ready_i; the second instruction appears the following cycle with no loss or duplication.
6. Assert flush_i together with an input transfer → dec_valid_o=0 next cycle. Assert rst_i while an entry is stalled → all outputs 0 next cycle.
